// File: rtl/mips_mem_pkg.sv
// Shared MIPS data-memory types: access sizes, store entries and the lane
// decoder used by both the store aligner and the load extractor.
package mips_mem_pkg;

  localparam int MEM_ADDR_W = 32;

  typedef enum logic [1:0] {SZ_BYTE, SZ_HALF, SZ_WORD, SZ_RSVD} mem_size_t;

  typedef struct packed {
    logic [MEM_ADDR_W-1:0] addr;
    logic [31:0]           wdata;
    logic [3:0]            be;
  } store_entry_t;

  typedef struct packed {
    logic         legal;
    store_entry_t entry;
  } store_align_t;

  // Replicate the narrow datum across every lane so the byte enables alone
  // select the target bytes; memory never needs a shifter.
  function automatic store_align_t align_store(input logic [MEM_ADDR_W-1:0] addr,
                                               input logic [31:0]           wdata,
                                               input mem_size_t             size);
    store_align_t r;
    r.legal       = 1'b0;
    r.entry.addr  = {addr[MEM_ADDR_W-1:2], 2'b00};
    r.entry.wdata = wdata;
    r.entry.be    = 4'b0000;
    case (size)
      SZ_BYTE: begin
        r.legal       = 1'b1;
        r.entry.wdata = {4{wdata[7:0]}};
        r.entry.be    = 4'b0001 << addr[1:0];
      end
      SZ_HALF: begin
        r.legal       = ~addr[0];
        r.entry.wdata = {2{wdata[15:0]}};
        r.entry.be    = addr[1] ? 4'b1100 : 4'b0011;
      end
      SZ_WORD: begin
        r.legal    = (addr[1:0] == 2'b00);
        r.entry.be = 4'b1111;
      end
      default: r.legal = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/store_fifo.sv
// Generic synchronous FIFO, power-of-two depth, pointers wrap naturally.
module store_fifo #(
  parameter int  DEPTH = 2,
  parameter type T     = logic [7:0],
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  T                 din,
  output T                 dout,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  T                 mem_q [DEPTH];
  T                 mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  assign full    = (count_q == CNT_W'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign dout    = mem_q[rd_ptr_q];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = din;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (do_pop) rd_ptr_d = rd_ptr_q + 1'b1;
    if (do_push && !do_pop)      count_d = count_q + 1'b1;
    else if (do_pop && !do_push) count_d = count_q - 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is only observed through a non-zero count, so it needs no reset.
  always_ff @(posedge clk) mem_q <= mem_d;

endmodule

// File: rtl/store_align_buffer.sv
// Store path between MEM stage and data memory: lane alignment, misalignment
// trap, and an in-order store buffer drained over valid/ready.
module store_align_buffer
  import mips_mem_pkg::*;
#(
  parameter int DEPTH  = 2,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  input  logic [1:0]        req_size,
  output logic              mem_valid,
  input  logic              mem_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [3:0]        mem_be,
  output logic              misalign_err,
  output logic [ADDR_W-1:0] err_addr,
  output logic              empty
);

  localparam int CNT_W = $clog2(DEPTH + 1);

  store_align_t     aligned;
  store_entry_t     head;
  logic             fifo_full, fifo_empty, accept, push, pop;
  logic [CNT_W-1:0] fifo_count;
  logic             misalign_err_q, misalign_err_d;
  logic [ADDR_W-1:0] err_addr_q, err_addr_d;

  assign aligned = align_store(MEM_ADDR_W'(req_addr), req_wdata, mem_size_t'(req_size));

  // Ready depends only on buffer occupancy, never on mem_ready.
  assign req_ready = !fifo_full;
  assign accept    = req_valid && req_ready;
  assign push      = accept && aligned.legal;
  assign mem_valid = (fifo_count != '0);
  assign pop       = mem_valid && mem_ready;
  assign empty     = fifo_empty;

  store_fifo #(.DEPTH(DEPTH), .T(store_entry_t)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .din   (aligned.entry),
    .dout  (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // Zero the bus when idle so no stale entry is ever visible after a drain or reset.
  assign mem_addr  = mem_valid ? ADDR_W'(head.addr) : '0;
  assign mem_wdata = mem_valid ? head.wdata : '0;
  assign mem_be    = mem_valid ? head.be : '0;

  always_comb begin
    misalign_err_d = accept && !aligned.legal;
    err_addr_d     = err_addr_q;
    if (accept && !aligned.legal) err_addr_d = req_addr;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      misalign_err_q <= 1'b0;
      err_addr_q     <= '0;
    end else begin
      misalign_err_q <= misalign_err_d;
      err_addr_q     <= err_addr_d;
    end
  end

  assign misalign_err = misalign_err_q;
  assign err_addr     = err_addr_q;

endmodule
